// File: rtl/add_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// add_share_pkg
//   Shared types and constants for the add_share_arb block.
//   - state_t : FSM encoding (S_IDLE, S_CALC, S_HOLD)
//   - W_DEF   : default operand/sum width
//   - N_DEF   : default number of requesters
//   - wrap_inc: increment an index modulo n (round-robin pointer advance)
// -----------------------------------------------------------------------------
package add_share_pkg;

    localparam int W_DEF = 32;
    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Next index after idx, wrapping n-1 -> 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/add_share_arb_if.sv
// -----------------------------------------------------------------------------
// add_share_arb_if
//   Bundles the requester and result-side signals of add_share_arb.
//   Requester side : req[N], b_in[N*W], c_in[N*W] in; gnt[N] out
//   Result side    : sum[W], carry, res_id[IDW], res_valid out; res_ack in
//   Status         : busy out
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (requesters + result consumer)
// -----------------------------------------------------------------------------
interface add_share_arb_if
    import add_share_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int W   = W_DEF,
    parameter int IDW = $clog2(N)
) ();

    logic [N-1:0]   req;
    logic [N*W-1:0] b_in;
    logic [N*W-1:0] c_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   sum;
    logic           carry;
    logic [IDW-1:0] res_id;
    logic           res_valid;
    logic           res_ack;
    logic           busy;

    modport slave (
        input  req, b_in, c_in, res_ack,
        output gnt, sum, carry, res_id, res_valid, busy
    );

    modport master (
        output req, b_in, c_in, res_ack,
        input  gnt, sum, carry, res_id, res_valid, busy
    );

endinterface

// File: rtl/add_share_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker.
//   Scans req starting at rr_ptr and moving upward, wrapping N-1 -> 0; the
//   first set bit wins.
//   Ports:
//     req[N]       in  : request vector
//     rr_ptr[IDW]  in  : highest-priority index for this scan (must be < N)
//     onehot[N]    out : one-hot winner (all zero when no request)
//     idx[IDW]     out : binary index of the winner (0 when no request)
//     any          out : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import add_share_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] rr_ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx,
    output logic           any
);

    always_comb begin
        // NOTE: every output gets a default before the loop; a combinational
        // block with any path that leaves an output unassigned infers a latch.
        onehot = '0;
        idx    = '0;
        any    = |req;
        // Walk offsets from farthest to nearest so the nearest set bit to
        // rr_ptr is the last one written and therefore wins.
        for (int i = N - 1; i >= 0; i--) begin
            int k;
            k = (int'(rr_ptr) + i) % N;
            if (req[k]) begin
                idx = IDW'(k);
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/add_share_arb.sv
// -----------------------------------------------------------------------------
// add_share_arb
//   Round-robin arbiter and sequencer sharing one W-bit adder among N
//   requesters. The winner's operands are latched on its grant cycle, added
//   in a registered stage, and the tagged result is held until acknowledged.
//
//   Ports:
//     clk    in : system clock, rising edge
//     rst_n  in : asynchronous active-low reset, clears all state
//     bus       : add_share_arb_if.slave
//                 req/b_in/c_in/res_ack in;
//                 gnt/sum/carry/res_id/res_valid/busy out
//
//   Timing: req seen at edge t -> gnt pulse in cycle t+1 -> res_valid the
//   cycle after. An ack returns to IDLE; arbitration resumes on the next edge
//   with the advanced pointer, so back-to-back issue is every 3 cycles.
//   IDW must equal clog2(N).
// -----------------------------------------------------------------------------
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int W   = W_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    add_share_arb_if.slave    bus
);

    // ---------------------------------------------------------------- state
    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [W-1:0]   op_b_q, op_c_q;
    logic [W-1:0]   sum_q;
    logic           carry_q;
    logic [IDW-1:0] res_id_q;
    logic           res_valid_q;
    logic [N-1:0]   gnt_q;

    // FSM strobes
    logic grant_en;
    logic calc_en;
    logic ack_en;

    // Picker results
    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // ---------------------------------------------------- FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop in
            // the design samples pre-edge values, regardless of block order.
            state_q <= state_d;
        end
    end

    // ------------------------------------------- FSM next-state and strobes
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        calc_en  = 1'b0;
        ack_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_en = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                calc_en = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // res_ack only matters here; in IDLE/CALC it is ignored.
                if (bus.res_ack) begin
                    ack_en  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            gnt_q       <= '0;
        end else begin
            // gnt is a single-cycle pulse coinciding with the CALC state.
            gnt_q <= grant_en ? pick_onehot : '0;

            if (grant_en) begin
                // Operands are captured only here; later changes on b_in/c_in
                // cannot reach the adder.
                op_b_q   <= bus.b_in[pick_idx*W +: W];
                op_c_q   <= bus.c_in[pick_idx*W +: W];
                res_id_q <= pick_idx;
            end

            if (calc_en) begin
                {carry_q, sum_q} <= {1'b0, op_b_q} + {1'b0, op_c_q};
                res_valid_q      <= 1'b1;
            end

            if (ack_en) begin
                res_valid_q <= 1'b0;
                // The served requester drops to lowest priority next round.
                rr_ptr_q    <= IDW'(wrap_inc(32'(res_id_q), N));
            end
        end
    end

    // ------------------------------------------------------------- outputs
    assign bus.gnt       = gnt_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_add_share_arb.sv
// -----------------------------------------------------------------------------
// tb_add_share_arb
//   Directed bench for add_share_arb: a table of single-transaction vectors
//   with hand-computed results, then hand-written sequences for round-robin
//   order, back-pressure, operand capture timing and asynchronous reset.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_add_share_arb;
    import add_share_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    add_share_arb_if #(.N(N), .W(W), .IDW(IDW)) bus ();

    add_share_arb #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           slot;   // expected winner index
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [N-1:0] gnt;
        logic [W-1:0] sum;
        logic         carry;
    } vec_t;

    vec_t vecs[9];

    task automatic set_slot(input int k, input logic [W-1:0] b, input logic [W-1:0] c);
        bus.b_in[k*W +: W] = b;
        bus.c_in[k*W +: W] = c;
    endtask

    // Distinct junk in every slot, so a wrong winner gives a wrong sum.
    task automatic scramble();
        for (int k = 0; k < N; k++) begin
            set_slot(k, 32'hDEAD_0000 + W'(k), 32'hBEEF_0000 + W'(k));
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.res_ack = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance falling edges until a gnt appears, bounded.
    task automatic wait_gnt(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no gnt within 20 cycles", name);
        end
    endtask

    // One full result handshake with immediate ack; leaves the DUT in IDLE.
    task automatic ack_now();
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rr_order[5];
        int           ng;
        int           last_cyc;

        // winner slot and pointer history:
        // ptr 0 ->0->1 ; ->2->3 ; ->3->0 ; ->1->2 ; ->0->1 ; ->2->3 ;
        // 0101 from 3 -> 0 ; 0101 from 1 -> 2 ; 1010 from 3 -> 3
        vecs[0] = '{req:4'b0001, slot:0, b:32'd1,         c:32'd2,         gnt:4'b0001, sum:32'd3,         carry:1'b0};
        vecs[1] = '{req:4'b0100, slot:2, b:32'hFFFF_FFFF, c:32'd2,         gnt:4'b0100, sum:32'd1,         carry:1'b1};
        vecs[2] = '{req:4'b1000, slot:3, b:32'h8000_0000, c:32'h8000_0000, gnt:4'b1000, sum:32'd0,         carry:1'b1};
        vecs[3] = '{req:4'b0010, slot:1, b:32'h1234_5678, c:32'h1111_1111, gnt:4'b0010, sum:32'h2345_6789, carry:1'b0};
        vecs[4] = '{req:4'b0001, slot:0, b:32'hFFFF_FFFF, c:32'd0,         gnt:4'b0001, sum:32'hFFFF_FFFF, carry:1'b0};
        vecs[5] = '{req:4'b0100, slot:2, b:32'hFFFF_FFFF, c:32'hFFFF_FFFF, gnt:4'b0100, sum:32'hFFFF_FFFE, carry:1'b1};
        vecs[6] = '{req:4'b0101, slot:0, b:32'd7,         c:32'd8,         gnt:4'b0001, sum:32'd15,        carry:1'b0};
        vecs[7] = '{req:4'b0101, slot:2, b:32'd100,       c:32'd23,        gnt:4'b0100, sum:32'd123,       carry:1'b0};
        vecs[8] = '{req:4'b1010, slot:3, b:32'h0FFF_FFFF, c:32'd1,         gnt:4'b1000, sum:32'h1000_0000, carry:1'b0};

        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // ---------------------------------------------------- reset state
        do_reset();
        check("reset outputs",
              {bus.gnt, bus.sum, bus.carry, bus.res_id, bus.res_valid, bus.busy},
              {4'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0});

        // ------------------------------------------------- vector table
        for (int v = 0; v < 9; v++) begin
            scramble();
            set_slot(vecs[v].slot, vecs[v].b, vecs[v].c);
            bus.req = vecs[v].req;
            @(negedge clk);
            check($sformatf("vec%0d gnt", v), bus.gnt, vecs[v].gnt);
            check($sformatf("vec%0d grant-cycle valid/busy", v),
                  {bus.res_valid, bus.busy}, {1'b0, 1'b1});
            // Drop the request and disturb the winner's operands.
            bus.req = '0;
            scramble();
            @(negedge clk);
            check($sformatf("vec%0d result", v),
                  {bus.gnt, bus.res_valid, bus.res_id, bus.carry, bus.sum},
                  {4'b0, 1'b1, IDW'(vecs[v].slot), vecs[v].carry, vecs[v].sum});
            ack_now();
            check($sformatf("vec%0d after ack", v),
                  {bus.res_valid, bus.busy, bus.sum}, {1'b0, 1'b0, vecs[v].sum});
        end

        // -------------------------------- round robin with req=1111 held
        do_reset();
        bus.req  = 4'b1111;
        ng       = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                check($sformatf("rr grant %0d", ng), bus.gnt, rr_order[ng]);
                if (ng > 0) check($sformatf("rr interval %0d", ng), cyc - last_cyc, 3);
                last_cyc = cyc;
                ng++;
            end
            bus.res_ack = bus.res_valid;
        end
        if (ng < 5) begin
            checks++;
            errors++;
            $display("FAIL rr grants: got %0d grants expected 5", ng);
        end
        bus.req = '0;
        @(negedge clk);
        check("rr last result id", {bus.res_valid, bus.res_id}, {1'b1, 2'd0});
        ack_now();   // rr_ptr now 1

        // ------------------------------------------ back-pressure
        scramble();
        set_slot(0, 32'd10, 32'd20);
        bus.req = 4'b0001;
        wait_gnt("bp first gnt");
        check("bp first gnt", bus.gnt, 4'b0001);
        bus.req = 4'b0010;
        set_slot(1, 32'd5, 32'd5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("bp hold %0d", i),
                  {bus.gnt, bus.res_valid, bus.res_id, bus.sum, bus.busy},
                  {4'b0, 1'b1, 2'd0, 32'd30, 1'b1});
        end
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
        check("bp ack cycle", {bus.gnt, bus.res_valid}, {4'b0, 1'b0});
        @(negedge clk);
        check("bp pending gnt", bus.gnt, 4'b0010);

        // ------------------------- operand change after grant: b1 5 -> 9
        set_slot(1, 32'd9, 32'd5);
        bus.req = '0;
        @(negedge clk);
        check("late operand change", {bus.res_valid, bus.res_id, bus.sum}, {1'b1, 2'd1, 32'd10});
        ack_now();   // rr_ptr now 2

        // ------------------------------------------ async reset mid-op
        scramble();
        set_slot(2, 32'd3, 32'd4);
        bus.req = 4'b0100;
        wait_gnt("rst op gnt");
        check("rst op gnt", bus.gnt, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs",
              {bus.gnt, bus.sum, bus.carry, bus.res_id, bus.res_valid, bus.busy},
              {4'b0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0});
        bus.req = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post-reset quiet %0d", i),
                  {bus.gnt, bus.res_valid, bus.busy}, {4'b0, 1'b0, 1'b0});
        end
        set_slot(3, 32'd6, 32'd7);
        bus.req = 4'b1000;
        wait_gnt("post-reset gnt");
        check("post-reset gnt", bus.gnt, 4'b1000);
        bus.req = '0;
        @(negedge clk);
        check("post-reset result", {bus.res_valid, bus.res_id, bus.sum, bus.carry},
              {1'b1, 2'd3, 32'd13, 1'b0});
        ack_now();
        check("post-reset idle", {bus.res_valid, bus.busy}, {1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_share_arb.md
Name: add_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one W-bit adder (sum = b + c) among N requesters.
- Each requester presents an operand pair with a req/gnt handshake. The block latches the winner's operands, performs the add in a registered stage, and holds the tagged result until the consumer acknowledges it.
- Sits between operand sources and the single adder datapath; it is the only path by which requesters reach the adder.

Parameters:
- N, 4, number of requesters (2..16)
- W, 32, operand and sum width
- IDW, 2, width of requester index; must equal clog2(N)

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  reset, asynchronous and active-low; clears all state immediately
- req  input  N  request per requester; level, held until matching gnt bit seen
- b_in  input  N*W  operand b; requester k in bits [k*W +: W]
- c_in  input  N*W  operand c; requester k in bits [k*W +: W]
- gnt  output  N  one-hot, one-cycle pulse; operands of that requester were latched this cycle
- sum  output  W  registered sum, low W bits of b+c
- carry  output  1  bit W of b+c (unsigned overflow)
- res_id  output  IDW  index of requester owning sum
- res_valid  output  1  sum/carry/res_id valid; held until res_ack
- res_ack  input  1  consumer accepts result; sampled only while res_valid=1
- busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt=0, sum=0, carry=0, res_id=0, res_valid=0, busy=0, rr_ptr=0, latched operands=0.
  - Reset mid-operation discards the in-flight op; no gnt or res_valid is produced for it after release.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - If |req=1: winner = first set req bit scanning from rr_ptr upward, wrapping N-1 -> 0.
  - Latch b_in/c_in slices of the winner, set res_id=winner, pulse gnt[winner] for one cycle, go to CALC.
  - If req=0: stay in IDLE, all outputs unchanged.
- CALC (one cycle): {carry,sum} <= op_b + op_c at W+1 bits, res_valid <= 1, go to HOLD. gnt=0.
- HOLD:
  - sum, carry and res_id are stable while res_valid=1.
  - On res_ack=1: res_valid <= 0, rr_ptr <= (res_id+1) mod N, go to IDLE.
  - res_ack=0: stay in HOLD. res_ack outside HOLD is ignored.
- Latency and throughput:
  - Request seen at edge t -> gnt visible after edge t, i.e. in cycle t+1.
  - res_valid rises one cycle after gnt.
  - Minimum issue interval is 3 cycles with immediate ack.
- Arithmetic: unsigned; wrap at 2^W; carry reports the lost bit. Operands are sampled only on the gnt cycle; later changes to b_in/c_in do not affect the result.
- Fairness:
  - A requester that keeps req high after its gnt is treated as a new request.
  - rr_ptr advance guarantees every asserted req is served within N grants.
- Simultaneous events:
  - res_ack together with new req in HOLD: return to IDLE first; arbitration happens next cycle using the updated rr_ptr.
  - A req deasserted before gnt is legal and is simply not served.
- sum and carry retain their last value after ack until the next CALC.

Decomposition:
- Shared package add_share_pkg:
  - state enum constants S_IDLE=2'd0, S_CALC=2'd1, S_HOLD=2'd2
  - default widths W_DEF=32, N_DEF=4
- One natural sub-module: rr_pick. It is a combinational round-robin priority picker taking req[N] and rr_ptr[IDW] and producing a one-hot winner plus a binary index. It is reused by other arbiters in the codebase.

Test Plan:
- Reset then single request: req=4'b0001, b0=1, c0=2 -> gnt=0001 one cycle, next cycle res_valid=1, sum=3, carry=0, res_id=0; ack -> res_valid=0, busy=0.
- Overflow: b2=32'hFFFF_FFFF, c2=2 on req=0100 -> sum=1, carry=1, res_id=2.
- Round robin: req=1111 held, ack each result the cycle it appears -> gnt order 0001,0010,0100,1000,0001; grants 3 cycles apart.
- Back-pressure: res_ack withheld 5 cycles -> sum/res_id stable, no new gnt despite req=0010 pending; after ack, gnt=0010 two cycles later.
- Operand change after grant: b1 changes from 5 to 9 the cycle after gnt=0010, c1=5 -> sum=10, not 14.
- Async reset mid-op: drop rst_n during CALC (off-edge) -> outputs zero immediately; after release with req=0, no res_valid ever appears and next req=1000 wins with rr_ptr=0 scan.
